// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Byte-copy DMA engine sitting between the core load/store port and a
//   single-port 2^AW x DW data memory. While idle it passes core accesses
//   straight through to memory. On start it owns the memory port and copies
//   len bytes from src_addr to dst_addr, using one read cycle and one write
//   cycle per byte. Any core request made while the engine is active is
//   stalled until the engine returns to idle.
//
// Ports
//   CLK, reset            clock; synchronous active-high reset
//   start                 copy request (sampled only when idle)
//   src_addr, dst_addr    first source / destination byte address
//   len                   byte count 0..2^AW
//   busy                  copy in progress (read or write phase)
//   done                  one-cycle completion pulse
//   cpu_addr, cpu_read_en, cpu_write_en, cpu_wdata   core request
//   cpu_rdata, cpu_stall  core response
//   mem_addr, mem_read_en, mem_write_en, mem_wdata   memory request
//   mem_rdata             memory read data (combinational read)

module mem_copy_engine #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   input  logic [AW-1:0] cpu_addr,
   input  logic          cpu_read_en,
   input  logic          cpu_write_en,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   output logic [AW-1:0] mem_addr,
   output logic          mem_read_en,
   output logic          mem_write_en,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [AW-1:0]   r_src_ptr;
   logic [AW-1:0]   r_dst_ptr;
   logic [AW:0]     r_remaining;
   logic [DW-1:0]   r_buf;
   logic            w_cpu_req;
   logic            w_len_zero;
   logic            w_last_byte;

   assign w_cpu_req   = cpu_read_en | cpu_write_en;
   assign w_len_zero  = (len == '0);
   assign w_last_byte = (r_remaining == (AW+1)'(1));

   // Status is decoded from the state register only, so start has no
   // combinational path to busy/done.
   assign busy = (r_state == S_READ) || (r_state == S_WRITE);
   assign done = (r_state == S_DONE);

   // State register and datapath registers
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_src_ptr   <= '0;
         r_dst_ptr   <= '0;
         r_remaining <= '0;
         r_buf       <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            S_IDLE: begin
               if (start && !w_len_zero) begin
                  r_src_ptr   <= src_addr;
                  r_dst_ptr   <= dst_addr;
                  r_remaining <= len;
               end
            end
            S_READ: begin
               r_buf <= mem_rdata;
            end
            S_WRITE: begin
               // Pointers wrap independently at the top of memory.
               r_src_ptr   <= r_src_ptr + AW'(1);
               r_dst_ptr   <= r_dst_ptr + AW'(1);
               r_remaining <= r_remaining - (AW+1)'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state and memory/core port muxing
   always_comb begin
      w_next_state = r_state;
      mem_addr     = '0;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      mem_wdata    = '0;
      cpu_rdata    = '0;
      cpu_stall    = w_cpu_req;

      case (r_state)
         S_IDLE: begin
            // Transparent pass-through; address/data are zeroed when the
            // core is not accessing so the memory port is quiet.
            cpu_stall    = 1'b0;
            cpu_rdata    = mem_rdata;
            mem_read_en  = cpu_read_en;
            mem_write_en = cpu_write_en;
            if (w_cpu_req) begin
               mem_addr = cpu_addr;
            end
            if (cpu_write_en) begin
               mem_wdata = cpu_wdata;
            end
            if (start) begin
               w_next_state = w_len_zero ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            mem_addr     = r_src_ptr;
            mem_read_en  = 1'b1;
            w_next_state = S_WRITE;
         end
         S_WRITE: begin
            mem_addr     = r_dst_ptr;
            mem_write_en = 1'b1;
            mem_wdata    = r_buf;
            w_next_state = w_last_byte ? S_DONE : S_READ;
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

endmodule
